led_counter_arbiter: RTL
========================

// Module: led_counter_arbiter
//
// PURPOSE
//   Shares one WIDTH-bit LED counter register between NUM_REQ debounced button
//   requesters. Each requester's one-cycle press pulse carries a 2-bit opcode.
//   The press is latched as pending, then served by a round-robin arbiter and
//   applied to the counter, so simultaneous presses are not lost.
//   Sits between the per-button debouncers and the LED pins.
//
// PARAMETERS
//   NUM_REQ      4    number of requesters (2..8)
//   WIDTH        4    counter / LED width
//   HOLD_CYCLES  12   lockout cycles after each update (0 = none); width 24 bits
//
// PORTS
//   clk        in   1          system clock (12 MHz), single clock domain
//   rst        in   1          synchronous, active-high reset
//   req_pulse  in   NUM_REQ    1-cycle press pulse per requester
//   req_op     in   2*NUM_REQ  opcode per requester, sampled with its pulse:
//                              00 inc, 01 dec, 10 clear, 11 nop
//   count      out  WIDTH      shared counter, drives the LEDs
//   grant      out  NUM_REQ    one-hot, high for the one cycle a request is served
//   busy       out  1          high in APPLY and HOLD
//   dropped    out  8          saturating count of presses lost to a full slot
//
// BEHAVIOUR
//   - Reset: count=0, grant=0, busy=0, dropped=0, all pending clear,
//     state=IDLE, round-robin pointer=0 (requester 0 has highest priority).
//     Reset mid-operation aborts the operation; the pending update is not applied.
//   - Pending slot i: one bit plus a 2-bit op.
//     - Set on req_pulse[i]; the op is latched from req_op[2i+1:2i].
//     - If the slot is already set and not being granted this cycle:
//       the new press is dropped and dropped increments (saturates at 255).
//     - If a press arrives in the same cycle as slot i's grant:
//       the slot reloads with the new op and stays set; nothing is dropped.
//   - FSM states IDLE, APPLY, HOLD (2-bit encoding; unused codes go to IDLE).
//     - IDLE: if any slot is pending, pick the winner with a round-robin search
//       starting at ptr.
//       - Register grant = onehot(winner) and clear the winner's slot.
//       - Latch the winner's op, set ptr = (winner+1) mod NUM_REQ, go to APPLY.
//     - APPLY: apply the op to count, clear grant.
//       - Go to HOLD if HOLD_CYCLES > 0, else go to IDLE.
//     - HOLD: a counter runs from 0 to HOLD_CYCLES-1, then the FSM goes to IDLE.
//       The counter is zeroed outside HOLD.
//   - Latency from idle:
//     - Press in cycle 0: pending visible in cycle 1.
//     - grant is high in cycle 2.
//     - The new count is visible in cycle 3.
//   - Back-to-back service: one request per (2 + HOLD_CYCLES) cycles.
//   - Pending presses accumulate during APPLY and HOLD; none are lost unless
//     the same slot is hit twice.
//   - Arithmetic is modulo 2^WIDTH unless SATURATE_EN is defined.
//     - inc at all-ones wraps to 0; dec at 0 wraps to all-ones.
//     - clear sets count to 0; nop leaves count unchanged but still consumes
//       a grant and the hold.
//
// CONFIGURATION
//   SATURATE_EN (defined): inc at all-ones holds all-ones; dec at 0 holds 0.
//   SATURATE_EN (undefined): wrap-around as above. No other differences.
//
// TESTING (HOLD_CYCLES=4, NUM_REQ=4, WIDTH=4 unless stated)
//   1. Reset, then pulse req 0 with op inc in cycle 0
//      -> grant=0001 in cycle 2; count=1 in cycle 3; busy for 5 cycles.
//   2. Same-cycle pulses on req 0, 1, 2 (all inc)
//      -> grants in order 0001, 0010, 0100, spaced 6 cycles apart;
//         final count=3; dropped=0.
//   3. count=15, req 1 inc -> count=0 (wrap). Then dec at 0 -> count=15.
//      With SATURATE_EN: 15 stays 15; 0 stays 0.
//   4. Two pulses on req 3 while busy, before it is served
//      -> dropped=1; only one update is applied.
//      A press coincident with req 3's grant -> served later; dropped unchanged.
//   5. Assert rst in the APPLY cycle of a pending dec from count=5
//      -> next cycle count=0, grant=0, busy=0, all pending clear.
//   6. Saturation and fairness:
//      - 300 dropped presses -> dropped=255.
//      - req 0 pulsing continuously alongside req 2 -> grants alternate 0 and 2.

Source files
------------

// File: rtl/led_counter_arbiter.sv
// Round-robin arbiter serving NUM_REQ button requesters onto one shared LED counter.
// Optional macro SATURATE_EN: inc/dec saturate instead of wrapping.
module led_counter_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 4,
   parameter int HOLD_CYCLES = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_pulse,
   input  logic [2*NUM_REQ-1:0]   req_op,
   output logic [WIDTH-1:0]       count,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic [7:0]             dropped
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                    state, state_nxt;
   logic [NUM_REQ-1:0]        pend;
   logic [NUM_REQ-1:0][1:0]   pend_op;
   logic [PW-1:0]             ptr;
   logic [1:0]                cur_op;
   logic [23:0]               hold_cnt;
   logic                      found, take, hold_done;
   logic [PW-1:0]             winner;
   logic [NUM_REQ-1:0]        win_oh, drop_vec;
   logic [3:0]                drop_n;
   logic [8:0]                drop_sum;
   int                        idx;

   // Round-robin search: first pending slot at or after ptr.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && pend[idx]) begin
            found  = 1'b1;
            winner = PW'(idx);
         end
      end
   end

   assign take      = (state == IDLE) && found;
   assign win_oh    = take ? (NUM_REQ'(1) << winner) : '0;
   assign hold_done = (hold_cnt == 24'(HOLD_CYCLES - 1));
   assign busy      = (state == APPLY) || (state == HOLD);

   // A press on a slot that is being granted this cycle reloads it instead of dropping.
   assign drop_vec = req_pulse & pend & ~win_oh;

   always_comb begin
      drop_n = '0;
      for (int i = 0; i < NUM_REQ; i++)
         drop_n = drop_n + {3'b000, drop_vec[i]};
      drop_sum = {1'b0, dropped} + {5'b00000, drop_n};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = APPLY;
         APPLY:   state_nxt = (HOLD_CYCLES > 0) ? HOLD : IDLE;
         HOLD:    if (hold_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         grant    <= '0;
         dropped  <= '0;
         pend     <= '0;
         pend_op  <= '0;
         ptr      <= '0;
         cur_op   <= 2'b11;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= win_oh;
         hold_cnt <= (state == HOLD && !hold_done) ? hold_cnt + 24'd1 : 24'd0;
         dropped  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         if (take) begin
            cur_op <= pend_op[winner];
            ptr    <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) pend[i] <= 1'b0;
            if (req_pulse[i] && !drop_vec[i]) begin
               pend[i]    <= 1'b1;
               pend_op[i] <= req_op[2*i +: 2];
            end
         end
         if (state == APPLY) begin
            case (cur_op)
`ifdef SATURATE_EN
               2'b00:   if (count != '1) count <= count + 1'b1;
               2'b01:   if (count != '0) count <= count - 1'b1;
`else
               2'b00:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
`endif
               2'b10:   count <= '0;
               default: count <= count;
            endcase
         end
      end
   end

endmodule
